// File: rtl/regfile_mp_sb_if.sv
// Register file bus: two write ports, NUM_RD packed read ports and the scoreboard.
// Latency: none (wires only); the slave side registers every output.
// Backpressure: none; every field is sampled on every clock edge.
interface regfile_mp_sb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2
);
  logic                           we0;
  logic [ADDR_WIDTH-1:0]          wa0;
  logic [DATA_WIDTH-1:0]          wd0;
  logic                           we1;
  logic [ADDR_WIDTH-1:0]          wa1;
  logic [DATA_WIDTH-1:0]          wd1;
  logic [NUM_RD*ADDR_WIDTH-1:0]   ra;
  logic [NUM_RD*DATA_WIDTH-1:0]   rdata;
  logic [NUM_RD-1:0]              rbusy;
  logic                           sb_set;
  logic [ADDR_WIDTH-1:0]          sb_addr;
  logic [ADDR_WIDTH:0]            busy_cnt;

  // Decode/writeback side: drives writes, read addresses and scoreboard sets.
  modport master (
    output we0, wa0, wd0, we1, wa1, wd1, ra, sb_set, sb_addr,
    input  rdata, rbusy, busy_cnt
  );

  // Register file side.
  modport slave (
    input  we0, wa0, wd0, we1, wa1, wd1, ra, sb_set, sb_addr,
    output rdata, rbusy, busy_cnt
  );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-port register file: 2 write ports, NUM_RD registered read ports, pending-write scoreboard.
// Latency: 1 cycle read, write-first (same-edge writes are bypassed; wd1 beats wd0 beats array).
// Backpressure: none; writes, reads and scoreboard sets are accepted every cycle.
module regfile_mp_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,
  parameter int ZERO_REG   = 1
) (
  input logic           clk,
  input logic           rst,
  regfile_mp_sb_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0]        regs [DEPTH];
  logic [DEPTH-1:0]             busy;
  logic [DEPTH-1:0]             busy_nxt;
  logic [CW-1:0]                busy_cnt_q;
  logic [CW-1:0]                busy_cnt_nxt;
  logic [NUM_RD*DATA_WIDTH-1:0] rdata_q;
  logic [NUM_RD*DATA_WIDTH-1:0] rdata_nxt;
  logic [NUM_RD-1:0]            rbusy_q;
  logic [NUM_RD-1:0]            rbusy_nxt;
  logic [ADDR_WIDTH-1:0]        rd_addr [NUM_RD];

  logic wr0_ok, wr1_ok, set_ok;
  logic cnt_inc, cnt_clr0, cnt_clr1;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_addr
    assign rd_addr[k] = bus.ra[k*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Accepted writes/sets: register 0 is hardwired when ZERO_REG is set.
  always_comb begin
    wr0_ok = bus.we0    && !((ZERO_REG != 0) && (bus.wa0     == '0));
    wr1_ok = bus.we1    && !((ZERO_REG != 0) && (bus.wa1     == '0));
    set_ok = bus.sb_set && !((ZERO_REG != 0) && (bus.sb_addr == '0));
  end

  // Next busy vector: clears from both writes first, then the set so a new producer wins.
  always_comb begin
    busy_nxt = busy;
    if (wr0_ok) busy_nxt[bus.wa0] = 1'b0;
    if (wr1_ok) busy_nxt[bus.wa1] = 1'b0;
    if (set_ok) busy_nxt[bus.sb_addr] = 1'b1;
  end

  // Incremental popcount: +1 for a fresh set, -1 per distinct busy register actually cleared.
  always_comb begin
    cnt_inc  = set_ok && !busy[bus.sb_addr];
    cnt_clr0 = wr0_ok && busy[bus.wa0] && !(set_ok && (bus.sb_addr == bus.wa0));
    cnt_clr1 = wr1_ok && busy[bus.wa1] && !(set_ok && (bus.sb_addr == bus.wa1))
               && !(wr0_ok && (bus.wa0 == bus.wa1));
    busy_cnt_nxt = busy_cnt_q
                 + {{(CW-1){1'b0}}, cnt_inc}
                 - {{(CW-1){1'b0}}, cnt_clr0}
                 - {{(CW-1){1'b0}}, cnt_clr1};
  end

  // Read-port next values with write-first bypass and post-update busy lookup.
  always_comb begin
    rdata_nxt = '0;
    rbusy_nxt = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if ((ZERO_REG != 0) && (rd_addr[k] == '0))
        rdata_nxt[k*DATA_WIDTH +: DATA_WIDTH] = '0;
      else if (wr1_ok && (bus.wa1 == rd_addr[k]))
        rdata_nxt[k*DATA_WIDTH +: DATA_WIDTH] = bus.wd1;
      else if (wr0_ok && (bus.wa0 == rd_addr[k]))
        rdata_nxt[k*DATA_WIDTH +: DATA_WIDTH] = bus.wd0;
      else
        rdata_nxt[k*DATA_WIDTH +: DATA_WIDTH] = regs[rd_addr[k]];
      rbusy_nxt[k] = busy_nxt[rd_addr[k]];
    end
  end

  // Register array: port 1 is written last so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (wr0_ok) regs[bus.wa0] <= bus.wd0;
      if (wr1_ok) regs[bus.wa1] <= bus.wd1;
    end
  end

  // Scoreboard state and output flops; reset overrides any same-cycle write or set.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= '0;
      busy_cnt_q <= '0;
      rdata_q    <= '0;
      rbusy_q    <= '0;
    end else begin
      busy       <= busy_nxt;
      busy_cnt_q <= busy_cnt_nxt;
      rdata_q    <= rdata_nxt;
      rbusy_q    <= rbusy_nxt;
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.rbusy    = rbusy_q;
  assign bus.busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb (3 read ports, register 0 hardwired).
// The driver pushes one hand-computed expectation per clock; a monitor pops and compares.
// Expectations cover reset, bypass, port priority, zero register and scoreboard counting.
module tb_regfile_mp_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  regfile_mp_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)) bus ();

  regfile_mp_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string           name;
    logic [DW-1:0]   d0;
    logic [DW-1:0]   d1;
    logic [DW-1:0]   d2;
    logic [NR-1:0]   rb;
    logic [AW:0]     cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: one expectation per clock, sampled just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp({e.name, "/rd0"},  bus.rdata[0*DW +: DW], e.d0);
      cmp({e.name, "/rd1"},  bus.rdata[1*DW +: DW], e.d1);
      cmp({e.name, "/rd2"},  bus.rdata[2*DW +: DW], e.d2);
      cmp({e.name, "/rbusy"}, 32'(bus.rbusy), 32'(e.rb));
      cmp({e.name, "/cnt"},   32'(bus.busy_cnt), 32'(e.cnt));
    end
  end

  task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.we0 = 1'b1; bus.wa0 = a; bus.wd0 = d;
  endtask

  task automatic wr1(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.we1 = 1'b1; bus.wa1 = a; bus.wd1 = d;
  endtask

  task automatic sb(input logic [AW-1:0] a);
    bus.sb_set = 1'b1; bus.sb_addr = a;
  endtask

  task automatic setra(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    bus.ra = {a2, a1, a0};
  endtask

  // Push the expectation for the coming edge, clock once, then drop the one-shot strobes.
  task automatic cyc(input string nm, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                     input logic [DW-1:0] e2, input logic [NR-1:0] be, input logic [AW:0] ce);
    exp_t e;
    e.name = nm; e.d0 = e0; e.d1 = e1; e.d2 = e2; e.rb = be; e.cnt = ce;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.we0 = 1'b0;
    bus.we1 = 1'b0;
    bus.sb_set = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    bus.we0 = 1'b0; bus.wa0 = '0; bus.wd0 = '0;
    bus.we1 = 1'b0; bus.wa1 = '0; bus.wd1 = '0;
    bus.sb_set = 1'b0; bus.sb_addr = '0;
    bus.ra = '0;

    // Reset with every write/set strobe active: nothing may stick.
    for (int i = 0; i < 2; i++) begin
      rst = 1'b1; wr0(5, 32'h1111); wr1(6, 32'h2222); sb(9); setra(5, 6, 9);
      cyc("rst", 0, 0, 0, 3'b000, 6'd0);
    end
    cyc("post_rst", 0, 0, 0, 3'b000, 6'd0);

    // Write-first bypass, then the value held in the array.
    wr0(5, 32'hDEADBEEF);
    cyc("bypass_wr0", 32'hDEADBEEF, 0, 0, 3'b000, 6'd0);
    for (int i = 0; i < 3; i++) cyc("hold", 32'hDEADBEEF, 0, 0, 3'b000, 6'd0);

    // Same-address collision: port 1 wins, both via bypass and in the array.
    wr0(7, 32'h11); wr1(7, 32'h22); setra(7, 5, 0);
    cyc("collide_bypass", 32'h22, 32'hDEADBEEF, 0, 3'b000, 6'd0);
    cyc("collide_array", 32'h22, 32'hDEADBEEF, 0, 3'b000, 6'd0);

    // Independent bypasses on both write ports alongside an array read.
    wr0(8, 32'hA); wr1(9, 32'hB); setra(8, 9, 7);
    cyc("dual_bypass", 32'hA, 32'hB, 32'h22, 3'b000, 6'd0);

    // Register 0: writes and scoreboard sets are dropped.
    wr0(0, 32'hEEEE); wr1(0, 32'hFFFF); sb(0); setra(0, 0, 0);
    cyc("zero_wr", 0, 0, 0, 3'b000, 6'd0);
    cyc("zero_hold", 0, 0, 0, 3'b000, 6'd0);

    // Scoreboard set, set-wins-over-clear, dual clear.
    sb(3); setra(3, 4, 5);
    cyc("sb_set3", 0, 0, 32'hDEADBEEF, 3'b001, 6'd1);
    sb(4);
    cyc("sb_set4", 0, 0, 32'hDEADBEEF, 3'b011, 6'd2);
    wr0(3, 32'h33); sb(3);
    cyc("set_wins", 32'h33, 0, 32'hDEADBEEF, 3'b011, 6'd2);
    wr0(3, 32'h34); wr1(4, 32'h44);
    cyc("dual_clear", 32'h34, 32'h44, 32'hDEADBEEF, 3'b000, 6'd0);

    // Re-set of a busy register, write to a free register, double clear of one register.
    sb(10); setra(10, 11, 12);
    cyc("sb_set10", 0, 0, 0, 3'b001, 6'd1);
    sb(10);
    cyc("sb_reset_busy", 0, 0, 0, 3'b001, 6'd1);
    wr0(11, 32'h5);
    cyc("wr_not_busy", 0, 32'h5, 0, 3'b001, 6'd1);
    wr0(10, 32'h6); wr1(10, 32'h7);
    cyc("dbl_clear_same", 32'h7, 32'h5, 0, 3'b000, 6'd0);

    // Two clears and one fresh set in one edge: net -1.
    sb(12); setra(12, 13, 14);
    cyc("sb12", 0, 0, 0, 3'b001, 6'd1);
    sb(13);
    cyc("sb13", 0, 0, 0, 3'b011, 6'd2);
    wr0(12, 32'h1); wr1(13, 32'h2); sb(14);
    cyc("clr2_set1", 32'h1, 32'h2, 0, 3'b100, 6'd1);

    // Reset mid-run overrides a set and a write, and clears the array.
    rst = 1'b1; sb(15); wr0(14, 32'h9); setra(14, 5, 15);
    cyc("rst_override", 0, 0, 0, 3'b000, 6'd0);
    setra(14, 5, 7);
    cyc("post_rst2", 0, 0, 0, 3'b000, 6'd0);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
